// File: rtl/inert_model_pkg.sv
// ---------------------------------------------------------------------------
// inert_model_pkg
//   Shared constants and types for the inertial sensor model:
//   register addresses, the operating values of the config registers,
//   the default WHO_AM_I identity and the SPI responder state type.
// ---------------------------------------------------------------------------
package inert_model_pkg;

  localparam int DATA_W = 16;

  // Register map (7-bit addresses)
  localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
  localparam logic [6:0] ADDR_CTRL1_XL  = 7'h10;
  localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
  localparam logic [6:0] ADDR_CTRL5     = 7'h14;
  localparam logic [6:0] ADDR_PTCHL     = 7'h22;
  localparam logic [6:0] ADDR_PTCHH     = 7'h23;
  localparam logic [6:0] ADDR_AZL       = 7'h2C;
  localparam logic [6:0] ADDR_AZH       = 7'h2D;

  // Values the host writes to bring the sensor into operating mode
  localparam logic [7:0] OP_INT1_CTRL = 8'h02;
  localparam logic [7:0] OP_CTRL1_XL  = 8'h53;
  localparam logic [7:0] OP_CTRL2_G   = 8'h50;
  localparam logic [7:0] OP_CTRL5     = 8'h60;

  localparam logic [7:0] WHO_AM_I_DFLT = 8'h6A;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} spi_state_t;

endpackage

// File: rtl/inert_sensor_model_spi.sv
// ---------------------------------------------------------------------------
// spi_slv16
//   16-bit SPI mode-3 responder. SS_n/SCLK/MOSI are resynchronised to clk;
//   MOSI is sampled on SCLK rise, MISO advances on SCLK fall.
// Ports
//   clk, rst_n     system clock / async active-low reset
//   ss_n,sclk,mosi raw SPI inputs (asynchronous to clk)
//   rd_byte        read data for the addressed register (used when cmd_vld)
//   miso           serial read data, 0 while SS_n is high
//   ss_idle        synchronised SS_n level (1 = no frame in progress)
//   ss_rise        1-clk pulse on synchronised SS_n rise
//   cmd_vld        1-clk pulse on the clk the 8th SCLK rise is detected
//   frm_done       1-clk pulse on the clk the 16th SCLK rise is detected
//   cmd_byte       {R/W, addr}; live during CMD, held afterwards
//   data_byte      second byte of the frame, valid with frm_done
// ---------------------------------------------------------------------------
module spi_slv16
  import inert_model_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic [7:0] rd_byte,
  output logic       miso,
  output logic       ss_idle,
  output logic       ss_rise,
  output logic       cmd_vld,
  output logic       frm_done,
  output logic [7:0] cmd_byte,
  output logic [7:0] data_byte
);

  logic ss_ff1, ss_ff2, ss_ff3;
  logic sclk_ff1, sclk_ff2, sclk_ff3;
  logic mosi_ff1, mosi_ff2;
  logic ss_fall, sclk_rise, sclk_fall;

  spi_state_t  state;
  logic [3:0]  bit_cnt;
  logic [7:0]  rx_sr;
  logic [7:0]  cmd_q;
  logic [15:0] shift_reg;

  // SS flops reset low so that a frame still open across reset produces
  // no fall; only a genuine high-to-low transition starts the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_ff1   <= 1'b0;
      ss_ff2   <= 1'b0;
      ss_ff3   <= 1'b0;
      sclk_ff1 <= 1'b1;
      sclk_ff2 <= 1'b1;
      sclk_ff3 <= 1'b1;
      mosi_ff1 <= 1'b0;
      mosi_ff2 <= 1'b0;
    end else begin
      ss_ff1   <= ss_n;
      ss_ff2   <= ss_ff1;
      ss_ff3   <= ss_ff2;
      sclk_ff1 <= sclk;
      sclk_ff2 <= sclk_ff1;
      sclk_ff3 <= sclk_ff2;
      mosi_ff1 <= mosi;
      mosi_ff2 <= mosi_ff1;
    end
  end

  assign ss_fall   = ss_ff3 & ~ss_ff2;
  assign ss_rise   = ss_ff2 & ~ss_ff3;
  assign sclk_rise = sclk_ff2 & ~sclk_ff3;
  assign sclk_fall = ~sclk_ff2 & sclk_ff3;
  assign ss_idle   = ss_ff2;

  assign cmd_vld   = (state == CMD)  && sclk_rise && (bit_cnt == 4'd7)  && !ss_rise;
  assign frm_done  = (state == DATA) && sclk_rise && (bit_cnt == 4'd15) && !ss_rise;
  assign cmd_byte  = (state == CMD) ? {rx_sr[6:0], mosi_ff2} : cmd_q;
  assign data_byte = {rx_sr[6:0], mosi_ff2};
  assign miso      = ~ss_ff2 & shift_reg[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      rx_sr     <= 8'h00;
      cmd_q     <= 8'h00;
      shift_reg <= 16'h0000;
    end else if (ss_rise) begin
      state     <= IDLE;
      shift_reg <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state     <= CMD;
            bit_cnt   <= 4'd0;
            rx_sr     <= 8'h00;
            shift_reg <= 16'h0000;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            rx_sr   <= {rx_sr[6:0], mosi_ff2};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state <= DATA;
              cmd_q <= {rx_sr[6:0], mosi_ff2};
              // rx_sr[6] holds the R/W bit at this point
              if (rx_sr[6])
                shift_reg <= {rd_byte, 8'h00};
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            rx_sr   <= {rx_sr[6:0], mosi_ff2};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              state     <= DONE;
              shift_reg <= 16'h0000;
            end
          end else if (sclk_fall && (bit_cnt >= 4'd9)) begin
            // The fall right after bit 8 keeps the freshly loaded MSB on MISO;
            // each later fall presents the next bit.
            shift_reg <= {shift_reg[14:0], 1'b0};
          end
        end
        DONE: begin
          // Extra SCLKs are ignored until SS_n rises.
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/inert_sensor_model.sv
// ---------------------------------------------------------------------------
// inert_sensor_model
//   Behavioural-but-synthesizable model of the Segway inertial sensor as
//   seen over its 16-bit SPI link: config register file, pitch/AZ sample
//   shadows, new-sample interrupt.
// Ports
//   clk, rst_n            50 MHz clock, async active-low reset
//   SS_n, SCLK, MOSI      SPI inputs (mode 3), asynchronous to clk
//   MISO                  SPI read data
//   INT                   new-sample interrupt (level)
//   new_smpl              strobe: capture ptch_in/az_in
//   ptch_in, az_in        signed sample inputs
//   cfg_rdy               config registers hold their operating values
// Configuration
//   INERT_MODEL_AUTOGEN_EN  when defined, samples come from an internal
//                           counter/pattern every SMPL_PERIOD clks and the
//                           new_smpl/ptch_in/az_in ports are ignored.
// ---------------------------------------------------------------------------
module inert_sensor_model
  import inert_model_pkg::*;
#(
  parameter logic [7:0]  WHO_AM_I    = WHO_AM_I_DFLT,
  parameter logic [15:0] SMPL_PERIOD = 16'd2400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        new_smpl,
  input  logic [15:0] ptch_in,
  input  logic [15:0] az_in,
  output logic        cfg_rdy
);

  logic       ss_idle, ss_rise, cmd_vld, frm_done;
  logic [7:0] cmd_byte, data_byte, rd_byte;

  logic [7:0] int1_ctrl, ctrl1_xl, ctrl2_g, ctrl5;
  logic signed [DATA_W-1:0] ptch_sh, az_sh;
  logic signed [DATA_W-1:0] pend_ptch, pend_az;
  logic       pend;
  logic       int_q;

  logic                     smpl_stb;
  logic signed [DATA_W-1:0] smpl_ptch, smpl_az;
  logic smpl_take, smpl_now, pend_flush, int_set, int_clr, wr_en;

  function automatic logic [7:0] reg_read(input logic [6:0] addr);
    case (addr)
      ADDR_INT1_CTRL: reg_read = int1_ctrl;
      ADDR_WHO_AM_I:  reg_read = WHO_AM_I;
      ADDR_CTRL1_XL:  reg_read = ctrl1_xl;
      ADDR_CTRL2_G:   reg_read = ctrl2_g;
      ADDR_CTRL5:     reg_read = ctrl5;
      ADDR_PTCHL:     reg_read = ptch_sh[7:0];
      ADDR_PTCHH:     reg_read = ptch_sh[15:8];
      ADDR_AZL:       reg_read = az_sh[7:0];
      ADDR_AZH:       reg_read = az_sh[15:8];
      default:        reg_read = 8'h00;
    endcase
  endfunction

  spi_slv16 u_spi (
    .clk       (clk),
    .rst_n     (rst_n),
    .ss_n      (SS_n),
    .sclk      (SCLK),
    .mosi      (MOSI),
    .rd_byte   (rd_byte),
    .miso      (MISO),
    .ss_idle   (ss_idle),
    .ss_rise   (ss_rise),
    .cmd_vld   (cmd_vld),
    .frm_done  (frm_done),
    .cmd_byte  (cmd_byte),
    .data_byte (data_byte)
  );

  assign rd_byte = cmd_vld ? reg_read(cmd_byte[6:0]) : 8'h00;

`ifdef INERT_MODEL_AUTOGEN_EN
  logic [15:0]              gen_cnt;
  logic                     gen_stb;
  logic signed [DATA_W-1:0] gen_ptch, gen_az;

  // The pattern value is emitted with the strobe, then advanced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_cnt  <= 16'd0;
      gen_stb  <= 1'b0;
      gen_ptch <= '0;
      gen_az   <= '0;
    end else begin
      if (gen_cnt == SMPL_PERIOD - 16'd1) begin
        gen_cnt <= 16'd0;
        gen_stb <= 1'b1;
      end else begin
        gen_cnt <= gen_cnt + 16'd1;
        gen_stb <= 1'b0;
      end
      if (gen_stb) begin
        gen_ptch <= gen_ptch + 16'sd1;
        gen_az   <= gen_az - 16'sd1;
      end
    end
  end

  assign smpl_stb  = gen_stb;
  assign smpl_ptch = gen_ptch;
  assign smpl_az   = gen_az;
`else
  assign smpl_stb  = new_smpl;
  assign smpl_ptch = ptch_in;
  assign smpl_az   = az_in;
`endif

  // A sample arriving while a frame is open is parked in pend_* and only
  // published after SS_n rises, so a frame never sees torn data.
  assign smpl_take  = smpl_stb && int1_ctrl[1];
  assign smpl_now   = smpl_take && ss_idle;
  assign pend_flush = ss_rise && pend && !smpl_take;
  assign int_set    = smpl_now || pend_flush;
  assign int_clr    = frm_done && (cmd_byte == {1'b1, ADDR_AZH});
  assign wr_en      = frm_done && !cmd_byte[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1_ctrl <= 8'h00;
      ctrl1_xl  <= 8'h00;
      ctrl2_g   <= 8'h00;
      ctrl5     <= 8'h00;
      ptch_sh   <= '0;
      az_sh     <= '0;
      pend_ptch <= '0;
      pend_az   <= '0;
      pend      <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      if (wr_en) begin
        case (cmd_byte[6:0])
          ADDR_INT1_CTRL: int1_ctrl <= data_byte;
          ADDR_CTRL1_XL:  ctrl1_xl  <= data_byte;
          ADDR_CTRL2_G:   ctrl2_g   <= data_byte;
          ADDR_CTRL5:     ctrl5     <= data_byte;
          default: ;
        endcase
      end

      if (smpl_now) begin
        ptch_sh <= smpl_ptch;
        az_sh   <= smpl_az;
        pend    <= 1'b0;
      end else if (smpl_take) begin
        pend_ptch <= smpl_ptch;
        pend_az   <= smpl_az;
        pend      <= 1'b1;
      end else if (pend_flush) begin
        ptch_sh <= pend_ptch;
        az_sh   <= pend_az;
        pend    <= 1'b0;
      end

      if (int_set)
        int_q <= 1'b1;
      else if (int_clr)
        int_q <= 1'b0;
    end
  end

  assign INT     = int_q;
  assign cfg_rdy = (int1_ctrl == OP_INT1_CTRL) && (ctrl1_xl == OP_CTRL1_XL) &&
                   (ctrl2_g == OP_CTRL2_G) && (ctrl5 == OP_CTRL5);

endmodule

// File: tb/tb_inert_sensor_model.sv
module tb_inert_sensor_model;

  logic        clk;
  logic        rst_n;
  logic        SS_n, SCLK, MOSI;
  logic        MISO, INT, cfg_rdy;
  logic        new_smpl;
  logic [15:0] ptch_in, az_in;

  int n_tests = 0;
  int n_fail  = 0;

  inert_sensor_model dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .INT      (INT),
    .new_smpl (new_smpl),
    .ptch_in  (ptch_in),
    .az_in    (az_in),
    .cfg_rdy  (cfg_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Master side of one frame: SCLK half period 8 clk, MISO sampled just
  // before each rise. nbits < 16 with raise_ss=1 aborts the frame.
  task automatic spi_frame(input logic [15:0] tx, input int nbits,
                           input bit raise_ss, output logic [15:0] rx);
    rx   = 16'h0000;
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 15; i > 15 - nbits; i--) begin
      SCLK = 1'b0;
      MOSI = tx[i];
      repeat (8) @(negedge clk);
      rx[i] = MISO;
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
    end
    if (raise_ss) begin
      SS_n = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic smpl(input logic [15:0] p, input logic [15:0] a);
    @(negedge clk);
    ptch_in  = p;
    az_in    = a;
    new_smpl = 1'b1;
    @(negedge clk);
    new_smpl = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rd;
    logic        cfg;
    logic        irq;
  } vec_t;

  vec_t vecs[12];
  logic [15:0] rx;

  initial begin
    vecs[0]  = '{16'h0D02, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{16'h1053, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{16'h1150, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{16'h8D00, 8'h02, 1'b0, 1'b0};
    vecs[4]  = '{16'h9000, 8'h53, 1'b0, 1'b0};
    vecs[5]  = '{16'h9100, 8'h50, 1'b0, 1'b0};
    vecs[6]  = '{16'h1460, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{16'h9400, 8'h60, 1'b1, 1'b0};
    vecs[8]  = '{16'h8F00, 8'h6A, 1'b1, 1'b0};
    vecs[9]  = '{16'h8100, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{16'h0F55, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{16'h8F00, 8'h6A, 1'b1, 1'b0};

    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    new_smpl = 1'b0; ptch_in = 16'h0000; az_in = 16'h0000;
    repeat (5) @(negedge clk);
    chk("reset_miso", {15'd0, MISO}, 16'd0);
    chk("reset_int", {15'd0, INT}, 16'd0);
    chk("reset_cfg", {15'd0, cfg_rdy}, 16'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      spi_frame(vecs[v].frame, 16, 1'b1, rx);
      chk($sformatf("vec%0d_rd", v), {8'h00, rx[7:0]}, {8'h00, vecs[v].rd});
      chk($sformatf("vec%0d_cfg", v), {15'd0, cfg_rdy}, {15'd0, vecs[v].cfg});
      chk($sformatf("vec%0d_int", v), {15'd0, INT}, {15'd0, vecs[v].irq});
    end

    // Sample capture with SS_n high, then read back all four bytes
    smpl(16'h1234, 16'hFEDC);
    chk("smpl_int_set", {15'd0, INT}, 16'd1);
    spi_frame(16'hA200, 16, 1'b1, rx); chk("ptchl", {8'h00, rx[7:0]}, 16'h0034);
    spi_frame(16'hA300, 16, 1'b1, rx); chk("ptchh", {8'h00, rx[7:0]}, 16'h0012);
    spi_frame(16'hAC00, 16, 1'b1, rx); chk("azl", {8'h00, rx[7:0]}, 16'h00DC);
    chk("int_held_before_azh", {15'd0, INT}, 16'd1);
    spi_frame(16'hAD00, 16, 1'b1, rx); chk("azh", {8'h00, rx[7:0]}, 16'h00FE);
    chk("int_clr_after_azh", {15'd0, INT}, 16'd0);

    // New sample arrives during an AC00 frame
    fork
      spi_frame(16'hAC00, 16, 1'b1, rx);
      begin
        repeat (40) @(negedge clk);
        smpl(16'h5678, 16'h0A0B);
        repeat (20) @(negedge clk);
        chk("pend_int_low_in_frame", {15'd0, INT}, 16'd0);
      end
    join
    chk("pend_old_azl", {8'h00, rx[7:0]}, 16'h00DC);
    chk("pend_int_after_ss", {15'd0, INT}, 16'd1);
    spi_frame(16'hAC00, 16, 1'b1, rx); chk("pend_new_azl", {8'h00, rx[7:0]}, 16'h000B);
    spi_frame(16'hA200, 16, 1'b1, rx); chk("pend_new_ptchl", {8'h00, rx[7:0]}, 16'h0078);
    spi_frame(16'hAD00, 16, 1'b1, rx); chk("pend_new_azh", {8'h00, rx[7:0]}, 16'h000A);
    chk("pend_int_clr", {15'd0, INT}, 16'd0);

    // Aborted AD00 frame leaves INT set
    smpl(16'h1111, 16'h2222);
    chk("abort_int_set", {15'd0, INT}, 16'd1);
    spi_frame(16'hAD00, 10, 1'b1, rx);
    chk("abort_int_kept", {15'd0, INT}, 16'd1);
    spi_frame(16'h8F00, 16, 1'b1, rx); chk("abort_next_who", {8'h00, rx[7:0]}, 16'h006A);
    chk("abort_int_still", {15'd0, INT}, 16'd1);
    spi_frame(16'hAD00, 16, 1'b1, rx); chk("abort_azh", {8'h00, rx[7:0]}, 16'h0022);
    chk("abort_int_clr", {15'd0, INT}, 16'd0);

    // Interrupt disabled: samples dropped
    spi_frame(16'h0D00, 16, 1'b1, rx);
    chk("dis_cfg", {15'd0, cfg_rdy}, 16'd0);
    smpl(16'h9999, 16'h8888);
    chk("dis_int", {15'd0, INT}, 16'd0);
    spi_frame(16'hA200, 16, 1'b1, rx); chk("dis_ptchl", {8'h00, rx[7:0]}, 16'h0011);
    spi_frame(16'hAC00, 16, 1'b1, rx); chk("dis_azl", {8'h00, rx[7:0]}, 16'h0022);

    // Reset pulse in the middle of a read frame
    spi_frame(16'h0D02, 16, 1'b1, rx);
    chk("rst_pre_cfg", {15'd0, cfg_rdy}, 16'd1);
    smpl(16'h4321, 16'h8765);
    chk("rst_pre_int", {15'd0, INT}, 16'd1);
    spi_frame(16'h8F00, 11, 1'b0, rx);
    chk("rst_pre_miso", {15'd0, MISO}, 16'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_miso", {15'd0, MISO}, 16'd0);
    chk("rst_mid_int", {15'd0, INT}, 16'd0);
    chk("rst_mid_cfg", {15'd0, cfg_rdy}, 16'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_post_miso", {15'd0, MISO}, 16'd0);
    SS_n = 1'b1;
    SCLK = 1'b1;
    repeat (10) @(negedge clk);
    spi_frame(16'h8F00, 16, 1'b1, rx); chk("rst_post_who", {8'h00, rx[7:0]}, 16'h006A);
    spi_frame(16'h8D00, 16, 1'b1, rx); chk("rst_post_int1", {8'h00, rx[7:0]}, 16'h0000);
    spi_frame(16'hA300, 16, 1'b1, rx); chk("rst_post_ptchh", {8'h00, rx[7:0]}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
